// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller with multi-cycle unit and memory-wait handling.
// Stall/flush/forward decisions are combinational; FSM, perf counters and timeout flag are registered.
module hazard_ctrl_mc #(
    parameter int RA_W        = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [RA_W-1:0]  rs1_ID,
    input  logic [RA_W-1:0]  rs2_ID,
    input  logic [1:0]       optype_ID,
    input  logic [1:0]       optype_EXE,
    input  logic [1:0]       optype_MEM,
    input  logic [RA_W-1:0]  rd_EXE,
    input  logic [RA_W-1:0]  rd_MEM,
    input  logic             store_EXE,
    input  logic [RA_W-1:0]  rs2_EXE,
    input  logic             branch_taken_ID,
    input  logic             mc_start_EXE,
    input  logic             mc_done,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_DE_EN,
    output logic             reg_EM_EN,
    output logic             reg_MW_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic             reg_EM_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state,
    output logic             mem_timeout_err
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, MC_WAIT = 2'b10} state_t;

    localparam logic [1:0]       OP_ALU  = 2'b01;
    localparam logic [1:0]       OP_LOAD = 2'b10;
    localparam logic [1:0]       OP_BR   = 2'b11;
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [RA_W-1:0]  R0      = '0;

    state_t cur, nxt;
    logic memstall, mcstall, load_use, any_flush;
    logic [CNT_W-1:0] wait_cnt;

    assign memstall = mem_req_MEM & ~mem_ready;
    assign mcstall  = mc_start_EXE & ~mc_done;
    assign load_use = (optype_EXE == OP_LOAD) && (rd_EXE != R0) &&
                      ((rs1use_ID && rs1_ID == rd_EXE) || (rs2use_ID && rs2_ID == rd_EXE));

    function automatic logic [1:0] fwd(input logic used, input logic [RA_W-1:0] rs);
        fwd = 2'b00;
        if (used && rs != R0) begin
            if (optype_EXE == OP_ALU && rd_EXE == rs)       fwd = 2'b01;
            else if (rd_MEM == rs && optype_MEM == OP_ALU)  fwd = 2'b10;
            else if (rd_MEM == rs && optype_MEM == OP_LOAD) fwd = 2'b11;
        end
    endfunction

    assign forward_ctrl_A  = fwd(rs1use_ID, rs1_ID);
    assign forward_ctrl_B  = fwd(rs2use_ID, rs2_ID);
    assign forward_ctrl_ls = store_EXE && (optype_MEM == OP_LOAD) &&
                             (rs2_EXE == rd_MEM) && (rd_MEM != R0);

    // Priority: memory freeze > multi-cycle hold > load-use bubble > branch flush.
    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_EN    = 1'b1;
        reg_DE_EN    = 1'b1;
        reg_EM_EN    = 1'b1;
        reg_MW_EN    = 1'b1;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        reg_EM_flush = 1'b0;
        if (memstall) begin
            PC_EN_IF  = 1'b0;
            reg_FD_EN = 1'b0;
            reg_DE_EN = 1'b0;
            reg_EM_EN = 1'b0;
            reg_MW_EN = 1'b0;
        end else if (mcstall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_EN    = 1'b0;
            reg_EM_flush = 1'b1;
        end else if (load_use) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_flush = 1'b1;
        end else if (optype_ID == OP_BR && branch_taken_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    assign any_flush = reg_FD_flush | reg_DE_flush | reg_EM_flush;

    always_comb begin
        nxt = cur;
        case (cur)
            RUN:      if (memstall) nxt = MEM_WAIT;
                      else if (mcstall) nxt = MC_WAIT;
            MEM_WAIT: if (!memstall) nxt = mcstall ? MC_WAIT : RUN;
            MC_WAIT:  if (memstall) nxt = MEM_WAIT;
                      else if (!mcstall) nxt = RUN;
            default:  nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur             <= RUN;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            cur <= nxt;
            if (!PC_EN_IF && stall_cnt != '1) stall_cnt <= stall_cnt + ONE;
            if (any_flush && flush_cnt != '1) flush_cnt <= flush_cnt + ONE;
            if (cur != MEM_WAIT && nxt == MEM_WAIT) begin
                wait_cnt <= '0;
            end else if (cur == MEM_WAIT) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + ONE;
                if (wait_cnt == TMO_M1) mem_timeout_err <= 1'b1;
            end
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: forwarding, stalls, FSM, counters, timeout and saturation.
module tb_hazard_ctrl_mc;
    localparam int RA_W = 5, CNT_W = 4, TMO = 4;

    logic clk = 1'b0, rst_n;
    logic rs1use_ID, rs2use_ID, store_EXE, branch_taken_ID, mc_start_EXE, mc_done, mem_req_MEM, mem_ready;
    logic [RA_W-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
    logic [1:0] optype_ID, optype_EXE, optype_MEM;
    logic PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
    logic reg_FD_flush, reg_DE_flush, reg_EM_flush, forward_ctrl_ls, mem_timeout_err;
    logic [1:0] forward_ctrl_A, forward_ctrl_B, state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int vectors = 0, miscompares = 0;

    hazard_ctrl_mc #(.RA_W(RA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .optype_ID(optype_ID), .optype_EXE(optype_EXE),
        .optype_MEM(optype_MEM), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .store_EXE(store_EXE),
        .rs2_EXE(rs2_EXE), .branch_taken_ID(branch_taken_ID), .mc_start_EXE(mc_start_EXE),
        .mc_done(mc_done), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_DE_EN(reg_DE_EN), .reg_EM_EN(reg_EM_EN),
        .reg_MW_EN(reg_MW_EN), .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .reg_EM_flush(reg_EM_flush), .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state(state), .mem_timeout_err(mem_timeout_err));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1use_ID = 0; rs2use_ID = 0; rs1_ID = 0; rs2_ID = 0; rd_EXE = 0; rd_MEM = 0; rs2_EXE = 0;
        optype_ID = 0; optype_EXE = 0; optype_MEM = 0; store_EXE = 0; branch_taken_ID = 0;
        mc_start_EXE = 0; mc_done = 0; mem_req_MEM = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); rst_n = 1;
    endtask

    // {PC, FD, DE, EM, MW} enables and {FD, DE, EM} flushes packed together
    function automatic logic [7:0] ctl();
        return {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN, reg_FD_flush, reg_DE_flush, reg_EM_flush};
    endfunction

    initial begin
        idle(); rst_n = 0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_err", mem_timeout_err, 0);
        chk("rst_ctl_idle", ctl(), 8'b11111_000);
        rst_n = 1;

        // load-use bubble, then load result forwarded from MEM
        optype_EXE = 2'b10; rd_EXE = 5; rs1use_ID = 1; rs1_ID = 5; #1;
        chk("lu_ctl", ctl(), 8'b00111_010);
        tick();
        chk("lu_stall", stall_cnt, 1);
        chk("lu_flush", flush_cnt, 1);
        optype_EXE = 0; rd_EXE = 0; optype_MEM = 2'b10; rd_MEM = 5; #1;
        chk("lu_fwdA", forward_ctrl_A, 2'b11);
        chk("lu_ctl2", ctl(), 8'b11111_000);
        tick();
        chk("lu_stall2", stall_cnt, 1);

        // forwarding priority and exclusions
        idle();
        optype_EXE = 2'b01; rd_EXE = 7; optype_MEM = 2'b01; rd_MEM = 7;
        rs2use_ID = 1; rs2_ID = 7; rs1use_ID = 1; rs1_ID = 0; #1;
        chk("fwdB_exe", forward_ctrl_B, 2'b01);
        chk("fwdA_r0", forward_ctrl_A, 2'b00);
        optype_EXE = 2'b00; #1;
        chk("fwdB_memalu", forward_ctrl_B, 2'b10);
        optype_EXE = 2'b11; #1;
        chk("fwdB_exebr", forward_ctrl_B, 2'b10);
        rs2use_ID = 0; #1;
        chk("fwdB_unused", forward_ctrl_B, 2'b00);
        optype_MEM = 2'b11; rs1_ID = 7; #1;
        chk("fwdA_membr", forward_ctrl_A, 2'b00);

        // store-data forwarding from MEM load
        idle();
        store_EXE = 1; optype_MEM = 2'b10; rd_MEM = 9; rs2_EXE = 9; #1;
        chk("ls_hit", forward_ctrl_ls, 1);
        rd_MEM = 0; rs2_EXE = 0; #1;
        chk("ls_r0", forward_ctrl_ls, 0);

        // taken branch deferred behind a load-use stall
        idle(); do_reset();
        optype_ID = 2'b11; branch_taken_ID = 1;
        optype_EXE = 2'b10; rd_EXE = 5; rs1use_ID = 1; rs1_ID = 5; #1;
        chk("br_lu_fd", reg_FD_flush, 0);
        chk("br_lu_de", reg_DE_flush, 1);
        tick();
        optype_EXE = 0; rd_EXE = 0; #1;
        chk("br_fd", reg_FD_flush, 1);
        chk("br_pc", PC_EN_IF, 1);
        tick();
        chk("br_stall", stall_cnt, 1);
        chk("br_flush", flush_cnt, 2);

        // multi-cycle op: 4 cycles with done on the 4th
        idle(); do_reset();
        mc_start_EXE = 1; #1;
        chk("mc1_ctl", ctl(), 8'b00011_001);
        chk("mc1_state", state, 2'b00);
        tick(); #1;
        chk("mc2_state", state, 2'b10);
        chk("mc2_emfl", reg_EM_flush, 1);
        tick(); #1;
        chk("mc3_state", state, 2'b10);
        chk("mc3_emfl", reg_EM_flush, 1);
        tick();
        mc_done = 1; #1;
        chk("mc4_state", state, 2'b10);
        chk("mc4_ctl", ctl(), 8'b11111_000);
        tick();
        chk("mc_run", state, 2'b00);
        chk("mc_stall", stall_cnt, 3);
        chk("mc_flush", flush_cnt, 3);

        // memory freeze with timeout; a concurrent mc op waits behind it
        idle(); do_reset();
        mem_req_MEM = 1; mc_start_EXE = 1; #1;
        chk("mem_ctl", ctl(), 8'b00000_000);
        tick();
        chk("mem_state", state, 2'b01);
        tick(); tick(); tick();
        chk("mem_err_pre", mem_timeout_err, 0);
        tick();
        chk("mem_err_set", mem_timeout_err, 1);
        tick();
        chk("mem_state6", state, 2'b01);
        chk("mem_ctl6", ctl(), 8'b00000_000);
        mem_ready = 1; #1;
        chk("mem_rdy_ctl", ctl(), 8'b00011_001);
        tick();
        chk("mem_to_mc", state, 2'b10);
        chk("mem_err_hold", mem_timeout_err, 1);
        mc_done = 1; tick();
        chk("mem_run", state, 2'b00);
        chk("mem_stall", stall_cnt, 7);
        chk("mem_flush", flush_cnt, 1);
        idle(); tick();
        chk("mem_err_sticky", mem_timeout_err, 1);
        do_reset();
        chk("mem_err_clr", mem_timeout_err, 0);

        // reset mid MC_WAIT: outputs still combinational, counters frozen
        mc_start_EXE = 1; tick(); tick();
        chk("rmc_state", state, 2'b10);
        rst_n = 0; #1;
        chk("rmc_pc", PC_EN_IF, 0);
        tick();
        chk("rmc_state0", state, 2'b00);
        chk("rmc_stall0", stall_cnt, 0);
        tick();
        chk("rmc_stall1", stall_cnt, 0);

        // saturation of both counters
        rst_n = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", stall_cnt, 15);
        chk("sat_flush", flush_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
